// File: rtl/idss_ctrl.sv
// idss_ctrl: sequencer for the four-slot 3x3 input-window shift storage.
// Walks a feature map in 3-row bands and steers each fetched column into slot x mod 4.
//
// Ports:
//   clk, rst_in              clock, synchronous active-high reset
//   start, cfg_width/height  one-cycle start pulse and map dimensions
//   col_x/col_y/col_ready    column request to the fetcher (valid/ready)
//   col_valid, col_r1..3     fetched column pixels (rows y, y+1, y+2)
//   row_1..3, le_select      registered pixels and target slot to storage
//   css_load, shift          storage write qualifier, window-advance strobe
//   win_valid/ready, win_x/y window handshake to the PE array
//   busy, done, cfg_err      status
module idss_ctrl #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int NB_SLOTS      = 4,
    parameter int COORD_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         rst_in,
    input  logic                         start,
    input  logic [COORD_WIDTH-1:0]       cfg_width,
    input  logic [COORD_WIDTH-1:0]       cfg_height,
    output logic [COORD_WIDTH-1:0]       col_x,
    output logic [COORD_WIDTH-1:0]       col_y,
    output logic                         col_ready,
    input  logic                         col_valid,
    input  logic [IO_DATA_WIDTH-1:0]     col_r1,
    input  logic [IO_DATA_WIDTH-1:0]     col_r2,
    input  logic [IO_DATA_WIDTH-1:0]     col_r3,
    output logic [IO_DATA_WIDTH-1:0]     row_1,
    output logic [IO_DATA_WIDTH-1:0]     row_2,
    output logic [IO_DATA_WIDTH-1:0]     row_3,
    output logic [$clog2(NB_SLOTS)-1:0]  le_select,
    output logic                         css_load,
    output logic                         shift,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [COORD_WIDTH-1:0]       win_x,
    output logic [COORD_WIDTH-1:0]       win_y,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int SW = $clog2(NB_SLOTS);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, WIN, DONE} state_t;

    state_t               state;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] x_last;
    logic [COORD_WIDTH-1:0] y_last;
    logic [SW-1:0]          slot;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            x_last    <= '0;
            y_last    <= '0;
            slot      <= '0;
            col_x     <= '0;
            col_y     <= '0;
            col_ready <= 1'b0;
            row_1     <= '0;
            row_2     <= '0;
            row_3     <= '0;
            le_select <= '0;
            css_load  <= 1'b0;
            shift     <= 1'b0;
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            shift    <= 1'b0;
            done     <= 1'b0;
            css_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        cfg_err <= 1'b0;
                        if (cfg_width < COORD_WIDTH'(3) ||
                            cfg_height < COORD_WIDTH'(3)) begin
                            cfg_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            // keep last x and last band top row for cheap compares
                            x_last    <= cfg_width - COORD_WIDTH'(1);
                            y_last    <= cfg_height - COORD_WIDTH'(3);
                            x         <= '0;
                            y         <= '0;
                            slot      <= '0;
                            col_x     <= '0;
                            col_y     <= '0;
                            col_ready <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (col_valid && col_ready) begin
                        row_1     <= col_r1;
                        row_2     <= col_r2;
                        row_3     <= col_r3;
                        le_select <= slot;
                        css_load  <= 1'b1;
                        col_ready <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (x >= COORD_WIDTH'(2)) begin
                        win_valid <= 1'b1;
                        win_x     <= x - COORD_WIDTH'(2);
                        win_y     <= y;
                        state     <= WIN;
                    end else begin
                        x         <= x + COORD_WIDTH'(1);
                        slot      <= slot + SW'(1);
                        col_x     <= x + COORD_WIDTH'(1);
                        col_ready <= 1'b1;
                        state     <= REQ;
                    end
                end
                WIN: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        shift     <= 1'b1;
                        if (x != x_last) begin
                            x         <= x + COORD_WIDTH'(1);
                            slot      <= slot + SW'(1);
                            col_x     <= x + COORD_WIDTH'(1);
                            col_ready <= 1'b1;
                            state     <= REQ;
                        end else if (y != y_last) begin
                            // next band: storage is refilled from column 0
                            x         <= '0;
                            slot      <= '0;
                            y         <= y + COORD_WIDTH'(1);
                            col_x     <= '0;
                            col_y     <= y + COORD_WIDTH'(1);
                            col_ready <= 1'b1;
                            state     <= REQ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idss_ctrl.sv
// tb_idss_ctrl: scoreboard bench for idss_ctrl.
// Directed runs push expected columns/windows; a negedge monitor pops and compares.
module tb_idss_ctrl;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start;
    logic [9:0]  cfg_width;
    logic [9:0]  cfg_height;
    logic [9:0]  col_x;
    logic [9:0]  col_y;
    logic        col_ready;
    logic        col_valid;
    logic [15:0] col_r1;
    logic [15:0] col_r2;
    logic [15:0] col_r3;
    logic [15:0] row_1;
    logic [15:0] row_2;
    logic [15:0] row_3;
    logic [1:0]  le_select;
    logic        css_load;
    logic        shift;
    logic        win_valid;
    logic        win_ready;
    logic [9:0]  win_x;
    logic [9:0]  win_y;
    logic        busy;
    logic        done;
    logic        cfg_err;

    idss_ctrl dut (
        .clk(clk), .rst_in(rst_in), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .col_x(col_x), .col_y(col_y), .col_ready(col_ready),
        .col_valid(col_valid), .col_r1(col_r1), .col_r2(col_r2), .col_r3(col_r3),
        .row_1(row_1), .row_2(row_2), .row_3(row_3),
        .le_select(le_select), .css_load(css_load), .shift(shift),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_x(win_x), .win_y(win_y),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
    } xy_t;

    xy_t exp_col[$];
    xy_t exp_win[$];
    xy_t pend[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int shift_cnt = 0;
    int col_cnt = 0;
    bit prev_hs = 0;
    bit xfer_seen = 0;
    bit gaps_on = 0;
    bit wr_low = 0;
    bit stall_y1 = 0;
    int gap = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int x, input int y, input int r);
        return 16'((r << 14) | ((y & 127) << 7) | (x & 127));
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({col_x, col_y, col_ready, row_1, row_2, row_3, le_select,
                     css_load, shift, win_valid, win_x, win_y, busy, done,
                     cfg_err});
    endfunction

    // fetcher: data always tracks the requested column; optional gaps per column
    initial begin
        col_valid = 1'b0;
        col_r1 = '0;
        col_r2 = '0;
        col_r3 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (xfer_seen) begin
                xfer_seen = 0;
                gap = gaps_on ? int'($urandom_range(0, 4)) : 0;
            end
            if (gap > 0) begin
                col_valid = 1'b0;
                gap--;
            end else begin
                col_valid = 1'b1;
            end
            col_r1 = pix(int'(col_x), int'(col_y), 1);
            col_r2 = pix(int'(col_x), int'(col_y), 2);
            col_r3 = pix(int'(col_x), int'(col_y), 3);
        end
    end

    // downstream consumer
    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            win_ready = !(wr_low || (stall_y1 && win_y == 10'd1));
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        xy_t e;
        bit hs;
        if (rst_in) begin
            prev_hs = 0;
        end else begin
            if (col_valid && col_ready) begin
                col_cnt++;
                xfer_seen = 1;
                if (exp_col.size() == 0) begin
                    chk("col_extra", 1, 0);
                end else begin
                    e = exp_col.pop_front();
                    chk("col_x", 128'(col_x), 128'(e.x));
                    chk("col_y", 128'(col_y), 128'(e.y));
                    pend.push_back(e);
                end
            end
            if (css_load) begin
                if (pend.size() == 0) begin
                    chk("load_extra", 1, 0);
                end else begin
                    e = pend.pop_front();
                    chk("le_select", 128'(le_select), 128'(e.x % 4));
                    chk("row_1", 128'(row_1), 128'(pix(e.x, e.y, 1)));
                    chk("row_2", 128'(row_2), 128'(pix(e.x, e.y, 2)));
                    chk("row_3", 128'(row_3), 128'(pix(e.x, e.y, 3)));
                end
                if (win_valid) chk("load_win_excl", 1, 0);
            end
            hs = win_valid && win_ready;
            if (hs) begin
                if (exp_win.size() == 0) begin
                    chk("win_extra", 1, 0);
                end else begin
                    e = exp_win.pop_front();
                    chk("win_x", 128'(win_x), 128'(e.x));
                    chk("win_y", 128'(win_y), 128'(e.y));
                end
            end
            if (shift || prev_hs) chk("shift", 128'(shift), 128'(prev_hs));
            if (shift) shift_cnt++;
            prev_hs = hs;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int w, input int h);
        for (int yy = 0; yy <= h - 3; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                exp_col.push_back('{xx, yy});
                if (xx >= 2) exp_win.push_back('{xx - 2, yy});
            end
        end
    endtask

    task automatic pulse_start(input int w, input int h);
        @(posedge clk);
        #1;
        cfg_width = 10'(w);
        cfg_height = 10'(h);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input int w, input int h, input bit gaps,
                       input bit hold10, input bit extra);
        bit seen;
        push_exp(w, h);
        gaps_on = gaps;
        done_cnt = 0;
        shift_cnt = 0;
        col_cnt = 0;
        if (hold10) wr_low = 1;
        pulse_start(w, h);
        if (hold10) begin
            seen = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (win_valid) begin
                    seen = 1;
                    break;
                end
            end
            chk("hold_wait_timeout", 128'(seen), 1);
            for (int i = 0; i < 10; i++) begin
                chk("hold_valid", 128'(win_valid), 1);
                chk("hold_x", 128'(win_x), 0);
                chk("hold_y", 128'(win_y), 0);
                chk("hold_col_ready", 128'(col_ready), 0);
                tick();
            end
            wr_low = 0;
        end
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (extra && i == 4) begin
                cfg_width = 10'd3;
                cfg_height = 10'd3;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (done_cnt > 0) begin
                seen = 1;
                break;
            end
        end
        chk("done_timeout", 128'(seen), 1);
        tick();
        chk("busy_after", 128'(busy), 0);
        chk("done_pulse", 128'(done), 0);
        chk("done_count", 128'(done_cnt), 1);
        chk("cfg_err_run", 128'(cfg_err), 0);
        chk("cols_left", 128'(exp_col.size()), 0);
        chk("wins_left", 128'(exp_win.size()), 0);
        chk("shift_count", 128'(shift_cnt), 128'((w - 2) * (h - 2)));
        chk("col_count", 128'(col_cnt), 128'(w * (h - 2)));
        gaps_on = 0;
    endtask

    initial begin
        bit seen;
        rst_in = 1'b1;
        start = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        tick();
        chk("reset_outs", all_outs(), 0);

        run(4, 3, 0, 0, 0);
        run(6, 5, 0, 0, 0);
        run(5, 3, 0, 1, 0);
        run(6, 5, 1, 0, 0);

        done_cnt = 0;
        pulse_start(2, 8);
        tick();
        chk("err_cfg_err", 128'(cfg_err), 1);
        chk("err_col_ready", 128'(col_ready), 0);
        chk("err_done_early", 128'(done), 0);
        tick();
        chk("err_done", 128'(done), 1);
        chk("err_busy", 128'(busy), 0);
        chk("err_col_ready2", 128'(col_ready), 0);
        run(3, 3, 0, 0, 0);

        push_exp(4, 4);
        stall_y1 = 1;
        pulse_start(4, 4);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (win_valid && win_y == 10'd1) begin
                seen = 1;
                break;
            end
        end
        chk("band1_timeout", 128'(seen), 1);
        rst_in = 1'b1;
        tick();
        chk("midrun_reset_outs", all_outs(), 0);
        rst_in = 1'b0;
        stall_y1 = 0;
        exp_col.delete();
        exp_win.delete();
        pend.delete();
        repeat (4) tick();
        chk("idle_after_reset", 128'({win_valid, col_ready, busy}), 0);

        run(5, 3, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idss_ctrl.md
Name: idss_ctrl

Overview:
- Sequencer for the four-slot 3x3 input-window shift storage (four CSS column slots fed by shared row_1/row_2/row_3 buses, slot chosen by a 2-bit LE_select, global shift).
- Walks a feature map in 3-row bands, stride 1. Fetches one 3-pixel column per step through a valid/ready handshake and steers it into slot x mod 4.
- Presents each complete 3x3 window to the downstream PE array with valid/ready and a shift strobe.
- Sits between the external-memory column fetcher and the window storage.

Parameters:
- IO_DATA_WIDTH, 16, pixel width.
- NB_SLOTS, 4, CSS column slots; fixed at 4 because LE_select is 2 bits.
- COORD_WIDTH, 10, width of x/y coordinates and runtime dimensions.

Ports:
- clk  in  1  clock.
- rst_in  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; latches cfg_width/cfg_height.
- cfg_width  in  COORD_WIDTH  feature-map width W.
- cfg_height  in  COORD_WIDTH  feature-map height H.
- col_x  out  COORD_WIDTH  column requested from fetcher.
- col_y  out  COORD_WIDTH  top row of the requested column.
- col_ready  out  1  controller can accept a column.
- col_valid  in  1  fetcher presents column data.
- col_r1/col_r2/col_r3  in  IO_DATA_WIDTH  pixels (y, y+1, y+2).
- row_1/row_2/row_3  out  IO_DATA_WIDTH  registered pixels to window storage.
- le_select  out  2  target slot.
- css_load  out  1  qualifies le_select; storage writes only when high.
- shift  out  1  one-cycle window-advance strobe.
- win_valid  out  1  complete window available.
- win_ready  in  1  downstream consumes window.
- win_x  out  COORD_WIDTH  left column of window.
- win_y  out  COORD_WIDTH  top row of window.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at end of map.
- cfg_err  out  1  sticky; set on illegal config, cleared by next start or reset.

Behaviour:
- Reset (rst_in=1 at posedge, any state, including mid-band):
  - state=IDLE.
  - All outputs 0, including row_*, le_select, coordinates and cfg_err.
  - Counters cleared. No partial window is emitted afterwards.
- States: IDLE, REQ, LOAD, WIN, DONE.
- IDLE:
  - start=1 with W>=3 and H>=3: latch W, H; x=0, y=0, slot=0; go to REQ.
  - start=1 with W<3 or H<3: cfg_err=1, go to DONE; no column is requested.
  - start while not IDLE is ignored.
- REQ:
  - col_ready=1; col_x=x and col_y=y, stable until transfer.
  - Transfer when col_valid && col_ready at posedge: register col_r1..3 into row_1..3, le_select=slot; go to LOAD.
  - col_valid without col_ready is held by the fetcher; no data is dropped.
- LOAD (exactly 1 cycle):
  - css_load=1; col_ready=0.
  - If x>=2: go to WIN with win_x=x-2, win_y=y.
  - Else: x++, slot=(slot+1) mod 4; go to REQ.
- WIN:
  - win_valid=1 and held, with win_x/win_y stable, until win_ready=1.
  - On win_valid && win_ready: shift=1 in the following cycle only; then advance.
  - Advance when x<W-1: x++, slot++ mod 4; go to REQ.
  - Advance when x=W-1 and y<H-3: x=0, slot=0, y++; go to REQ (band wrap, window storage refilled from column 0).
  - Advance when x=W-1 and y=H-3: go to DONE.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- Latency and throughput:
  - Column accept to css_load: 1 cycle.
  - css_load to win_valid: 1 cycle.
  - Best case: 1 window per 3 cycles.
  - First window of a band appears after 3 column loads.
- Counts:
  - Windows per band = W-2; total windows = (W-2)*(H-2).
  - Column fetches = W*(H-2); columns are refetched on every band.
- Slot rule:
  - le_select = x mod 4 and wraps 3->0 within a band.
  - Slot resets to 0 at each band start.
- win_ready high while win_valid is low has no effect.
- css_load and win_valid are never high in the same cycle.
- col_ready is 0 outside REQ.

Test Plan:
- Reset then start, W=4, H=3, fetcher always valid -> 4 column transfers (x=0..3, y=0), le_select 0,1,2,3; 2 windows (win_x=0,1; win_y=0); done pulse; busy low after.
- W=6, H=5, win_ready always 1 -> 18 column fetches, 12 windows in raster order; le_select sequence per band 0,1,2,3,0,1; slot back to 0 at band start; exactly one done.
- W=5, H=3, win_ready held low 10 cycles on first window -> win_valid, win_x=0 and win_y=0 stable all 10 cycles; col_ready=0 throughout; shift pulses exactly once after the handshake.
- Fetcher inserts random col_valid gaps (0-4 cycles) -> same window sequence and coordinates as the gap-free run; no data lost or duplicated.
- Start with W=2, H=8 -> no col_ready; cfg_err=1; done pulse 2 cycles after start. A new start with W=3, H=3 clears cfg_err and yields 1 window.
- rst_in asserted while in WIN at band y=1 -> next cycle all outputs 0, state IDLE. A subsequent start restarts from x=0, y=0; start pulses while busy are ignored.
